// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO-style UART transmitter
// between NUM_SRC valid/ready/last byte sources through a one-entry hold register.
module uart_tx_arbiter #(
    parameter int NUM_SRC        = 4,
    parameter int WORD_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    localparam int ID_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*WORD_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_last,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [WORD_WIDTH-1:0]         tx_din,
    output logic                          tx_empty,
    input  logic                          tx_re,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
    localparam int TO_MAX = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam int CNT_W  = (TO_MAX > 0) ? $clog2(TO_MAX + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ID_W-1:0]         rr;
    logic [ID_W-1:0]         sel;
    logic                    sel_found;
    logic                    hold_vld;
    logic [WORD_WIDTH-1:0]   hold_data;
    logic                    hold_last;
    logic                    pkt_done;
    logic [CNT_W-1:0]        cnt;
    logic                    accept;
    logic                    consume;
    logic                    idle_lock;
    logic                    timeout_hit;
    logic [WORD_WIDTH-1:0]   cur_data;
    logic                    cur_last;
    logic                    cur_valid;

    // Round-robin scan starting just after the last granted source
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_id;
        sel       = '0;
        sel_found = 1'b0;
        idx       = 0;
        idx_id    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx    = (int'(rr) + k) % NUM_SRC;
            idx_id = ID_W'(idx);
            if (!sel_found && src_valid[idx_id]) begin
                sel       = idx_id;
                sel_found = 1'b1;
            end
        end
    end

    assign cur_valid = src_valid[grant_id];
    assign cur_data  = src_data[int'(grant_id)*WORD_WIDTH +: WORD_WIDTH];
    assign cur_last  = src_last[grant_id];

    assign accept      = (state == LOCK) && cur_valid && !hold_vld && !pkt_done;
    assign consume     = (state == LOCK) && tx_re && hold_vld;
    assign idle_lock   = (state == LOCK) && !hold_vld && !pkt_done && !cur_valid;
    assign timeout_hit = TO_EN && idle_lock && (cnt == CNT_W'(TO_MAX));
    assign tx_empty    = !hold_vld;

    // Ready depends on registered state only, so sources never see a combinational loop
    always_comb begin
        src_ready = '0;
        if ((state == LOCK) && !hold_vld && !pkt_done) begin
            src_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_next = LOCK;
                end
            end
            LOCK: begin
                if ((consume && hold_last) || timeout_hit) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Accept, consume and timeout are mutually exclusive: each needs a different hold_vld/valid combination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id    <= '0;
            busy        <= 1'b0;
            rr          <= ID_W'(NUM_SRC - 1);
            hold_vld    <= 1'b0;
            hold_data   <= '0;
            hold_last   <= 1'b0;
            pkt_done    <= 1'b0;
            tx_din      <= '0;
            timeout_err <= 1'b0;
            cnt         <= '0;
        end else begin
            timeout_err <= 1'b0;
            if (state == IDLE) begin
                if (sel_found) begin
                    grant_id <= sel;
                    busy     <= 1'b1;
                    cnt      <= '0;
                end
            end else begin
                if (accept) begin
                    hold_vld  <= 1'b1;
                    hold_data <= cur_data;
                    hold_last <= cur_last;
                    cnt       <= '0;
                    if (cur_last) begin
                        pkt_done <= 1'b1;
                    end
                end else if (consume) begin
                    tx_din   <= hold_data;
                    hold_vld <= 1'b0;
                    if (hold_last) begin
                        busy     <= 1'b0;
                        rr       <= grant_id;
                        pkt_done <= 1'b0;
                    end
                end else if (timeout_hit) begin
                    busy        <= 1'b0;
                    rr          <= grant_id;
                    timeout_err <= 1'b1;
                    cnt         <= '0;
                end else if (TO_EN && idle_lock) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle-exact vector table plus scenario
// sequences driven by a small per-source packet queue model.
module tb_uart_tx_arbiter;

    localparam int NS = 4;
    localparam int WW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NS-1:0]   src_valid = '0;
    logic [NS*WW-1:0] src_data = '0;
    logic [NS-1:0]   src_last = '0;
    logic [NS-1:0]   src_ready;
    logic [WW-1:0]   tx_din;
    logic            tx_empty;
    logic            tx_re = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;

    uart_tx_arbiter #(
        .NUM_SRC(NS),
        .WORD_WIDTH(WW),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .src_valid(src_valid),
        .src_data(src_data),
        .src_last(src_last),
        .src_ready(src_ready),
        .tx_din(tx_din),
        .tx_empty(tx_empty),
        .tx_re(tx_re),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        re;
        logic [3:0]  exp_ready;
        logic        exp_empty;
        logic        exp_busy;
        logic [1:0]  exp_grant;
        logic [7:0]  exp_din;
        logic        exp_terr;
    } vec_t;

    typedef struct packed {
        logic [1:0] grant;
        logic [7:0] din;
    } rot_t;

    vec_t vecs [15];
    rot_t rot_exp [8];

    int checks = 0;
    int errors = 0;

    logic [8:0] fifo [NS][16];
    int         head [NS];
    int         tail [NS];
    logic [NS-1:0] fire;

    logic [1:0] obs_grant [32];
    logic [7:0] obs_din [32];
    logic       obs_busy [32];
    int         obs_cyc [32];
    int         obs_n;
    logic       pulled_prev;
    int         cyc;
    int         terr_cnt;
    int         terr_cyc;
    logic       terr_busy;
    logic [1:0] terr_grant;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < NS; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        fire        = '0;
        src_valid   = '0;
        src_data    = '0;
        src_last    = '0;
        tx_re       = 1'b0;
        obs_n       = 0;
        pulled_prev = 1'b0;
        cyc         = 0;
        terr_cnt    = 0;
        terr_cyc    = -1;
        terr_busy   = 1'b1;
        terr_grant  = 2'd0;
        for (int k = 0; k < 32; k++) begin
            obs_grant[k] = '0;
            obs_din[k]   = '0;
            obs_busy[k]  = 1'b0;
            obs_cyc[k]   = 0;
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        clearModel();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic enqueue(input int s, input logic [7:0] d, input logic l);
        fifo[s][tail[s]] = {l, d};
        tail[s]++;
    endtask

    // Sources advance one entry after each handshake seen on the previous edge
    task automatic driveSources();
        for (int i = 0; i < NS; i++) begin
            if (fire[i]) head[i]++;
            if (head[i] < tail[i]) begin
                src_valid[i]         = 1'b1;
                src_data[i*WW +: WW] = fifo[i][head[i]][7:0];
                src_last[i]          = fifo[i][head[i]][8];
            end else begin
                src_valid[i]         = 1'b0;
                src_data[i*WW +: WW] = '0;
                src_last[i]          = 1'b0;
            end
            fire[i] = src_valid[i] & src_ready[i];
        end
    endtask

    task automatic stepCycle(input logic re);
        @(negedge clk);
        cyc++;
        if (pulled_prev && obs_n < 32) begin
            obs_grant[obs_n] = grant_id;
            obs_din[obs_n]   = tx_din;
            obs_busy[obs_n]  = busy;
            obs_cyc[obs_n]   = cyc;
            obs_n++;
        end
        if (timeout_err) begin
            terr_cnt++;
            terr_cyc   = cyc;
            terr_busy  = busy;
            terr_grant = grant_id;
        end
        driveSources();
        tx_re       = re;
        pulled_prev = re && !tx_empty;
    endtask

    // Outputs are registered-state only, so they are checked before the new inputs are applied
    task automatic applyStimulus(input int i);
        @(negedge clk);
        checkOutput($sformatf("vec%0d", i),
                    {15'd0, src_ready, tx_empty, busy, grant_id, tx_din, timeout_err},
                    {15'd0, vecs[i].exp_ready, vecs[i].exp_empty, vecs[i].exp_busy,
                     vecs[i].exp_grant, vecs[i].exp_din, vecs[i].exp_terr});
        src_valid = vecs[i].valid;
        src_last  = vecs[i].last;
        src_data  = vecs[i].data;
        tx_re     = vecs[i].re;
    endtask

    initial begin
        logic [7:0] ok_bytes [3];
        ok_bytes[0] = 8'h4F;
        ok_bytes[1] = 8'h4B;
        ok_bytes[2] = 8'h0A;

        vecs[0]  = {4'b0101, 4'b0000, 32'h0030_0010, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0};
        vecs[1]  = {4'b0101, 4'b0000, 32'h0030_0010, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h00, 1'b0};
        vecs[2]  = {4'b0101, 4'b0001, 32'h0030_0011, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0};
        vecs[3]  = {4'b0101, 4'b0001, 32'h0030_0011, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h10, 1'b0};
        vecs[4]  = {4'b0100, 4'b0000, 32'h0030_0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h10, 1'b0};
        vecs[5]  = {4'b0100, 4'b0000, 32'h0030_0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h11, 1'b0};
        vecs[6]  = {4'b0100, 4'b0000, 32'h0030_0000, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h11, 1'b0};
        vecs[7]  = {4'b0100, 4'b0100, 32'h0031_0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h11, 1'b0};
        vecs[8]  = {4'b0100, 4'b0100, 32'h0031_0000, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h30, 1'b0};
        vecs[9]  = {4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h30, 1'b0};
        vecs[10] = {4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 8'h31, 1'b0};
        vecs[11] = {4'b0001, 4'b0001, 32'h0000_0012, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 8'h31, 1'b0};
        vecs[12] = {4'b0001, 4'b0001, 32'h0000_0012, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h31, 1'b0};
        vecs[13] = {4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h31, 1'b0};
        vecs[14] = {4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h12, 1'b0};

        rot_exp[0] = {2'd0, 8'hA0};
        rot_exp[1] = {2'd1, 8'hA1};
        rot_exp[2] = {2'd2, 8'hA2};
        rot_exp[3] = {2'd3, 8'hA3};
        rot_exp[4] = {2'd0, 8'hB0};
        rot_exp[5] = {2'd1, 8'hB1};
        rot_exp[6] = {2'd2, 8'hB2};
        rot_exp[7] = {2'd3, 8'hB3};

        // Two competing packets, release-before-rearbitrate, empty reads, re-request
        doReset();
        for (int i = 0; i < 15; i++) applyStimulus(i);

        // "OK\n" from source 1 with a slow transmitter
        doReset();
        enqueue(1, 8'h4F, 1'b0);
        enqueue(1, 8'h4B, 1'b0);
        enqueue(1, 8'h0A, 1'b1);
        for (int c = 0; c < 310; c++) stepCycle(c % 100 == 99);
        checkOutput("ok_count", obs_n, 3);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("ok_din%0d", k), {24'd0, obs_din[k]}, {24'd0, ok_bytes[k]});
            checkOutput($sformatf("ok_grant%0d", k), {30'd0, obs_grant[k]}, 32'd1);
            checkOutput($sformatf("ok_busy%0d", k), {31'd0, obs_busy[k]}, (k == 2) ? 32'd0 : 32'd1);
        end
        checkOutput("ok_spacing", obs_cyc[2] - obs_cyc[1], 100);

        // Strict rotation with every source requesting
        doReset();
        for (int i = 0; i < NS; i++) enqueue(i, 8'hA0 + 8'(i), 1'b1);
        for (int i = 0; i < NS; i++) enqueue(i, 8'hB0 + 8'(i), 1'b1);
        for (int c = 0; c < 60; c++) stepCycle(1'b1);
        checkOutput("rot_count", obs_n, 8);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("rot%0d", k), {22'd0, obs_grant[k], obs_din[k]}, {22'd0, rot_exp[k]});
        end

        // Source 3 stalls mid-packet; source 0 waits behind it
        doReset();
        enqueue(3, 8'h33, 1'b0);
        for (int c = 0; c < 100; c++) begin
            if (c == 3) enqueue(0, 8'h55, 1'b1);
            stepCycle(1'b1);
        end
        checkOutput("to_count", obs_n, 2);
        checkOutput("to_first", {22'd0, obs_grant[0], obs_din[0]}, {22'd0, 2'd3, 8'h33});
        checkOutput("to_pulses", terr_cnt, 1);
        checkOutput("to_delay", terr_cyc - obs_cyc[0], 50);
        checkOutput("to_busy", {31'd0, terr_busy}, 32'd0);
        checkOutput("to_grant", {30'd0, terr_grant}, 32'd3);
        checkOutput("to_next", {22'd0, obs_grant[1], obs_din[1]}, {22'd0, 2'd0, 8'h55});

        // Asynchronous reset while a byte sits in the hold register
        doReset();
        enqueue(0, 8'h61, 1'b1);
        for (int c = 0; c < 12; c++) stepCycle(1'b1);
        checkOutput("rst_pre", {22'd0, obs_grant[0], obs_din[0]}, {22'd0, 2'd0, 8'h61});
        enqueue(1, 8'h71, 1'b0);
        enqueue(1, 8'h72, 1'b1);
        for (int c = 0; c < 20 && !(busy && grant_id == 2'd1 && !tx_empty); c++) stepCycle(1'b0);
        checkOutput("rst_setup", {28'd0, busy, grant_id, tx_empty}, {28'd0, 1'b1, 2'd1, 1'b0});
        #2;
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOutput("rst_async", {18'd0, src_ready, tx_empty, busy, tx_din, timeout_err},
                    {18'd0, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        enqueue(0, 8'h62, 1'b1);
        enqueue(1, 8'h73, 1'b1);
        for (int c = 0; c < 30; c++) stepCycle(1'b1);
        checkOutput("rst_count", obs_n, 2);
        checkOutput("rst_first", {22'd0, obs_grant[0], obs_din[0]}, {22'd0, 2'd0, 8'h62});
        checkOutput("rst_second", {22'd0, obs_grant[1], obs_din[1]}, {22'd0, 2'd1, 8'h73});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (FIFO-style pull interface: din/empty/re) between NUM_SRC packet sources.
- Each source offers a byte stream with valid/ready/last handshake.
- Round-robin arbitration at packet granularity: once a source is granted, its packet goes out uninterrupted up to and including the last byte.
- Sits between status/message generators (heartbeat, debug, error reporters) and the transmitter instance.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8)
- WORD_WIDTH, 8, byte width; must match transmitter WORD_WIDTH
- TIMEOUT_CYCLES, 1_000_000, idle cycles tolerated inside a granted packet before forced release; 0 disables the timeout

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- src_valid  input  NUM_SRC  per-source byte valid
- src_data  input  NUM_SRC*WORD_WIDTH  per-source byte; source i at [i*WORD_WIDTH +: WORD_WIDTH]
- src_last  input  NUM_SRC  marks final byte of a packet
- src_ready  output  NUM_SRC  per-source byte accepted when valid&ready
- tx_din  output  WORD_WIDTH  byte to transmitter, registered
- tx_empty  output  1  no byte available to transmitter
- tx_re  input  1  transmitter read request
- grant_id  output  $clog2(NUM_SRC) (min 1)  currently or last granted source
- busy  output  1  a packet is locked
- timeout_err  output  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, rst_n=0): state IDLE, src_ready=0, tx_din=0, tx_empty=1, grant_id=0, busy=0, timeout_err=0, hold buffer empty, rr pointer = NUM_SRC-1 (so source 0 has first priority), timeout counter=0. Reset mid-packet drops the packet silently; no byte is emitted after reset.
- States: IDLE, LOCK.
- IDLE:
  - If any src_valid: select the first requester scanning rr+1, rr+2, … modulo NUM_SRC.
  - Next edge: grant_id<=sel, busy<=1, enter LOCK.
  - Arbitration costs exactly one cycle; no byte is accepted in IDLE (src_ready=0).
- LOCK, one-entry hold register (hold_vld, hold_data, hold_last):
  - src_ready[grant_id] = !hold_vld && !pkt_done. All other src_ready bits are 0. Ready is a combinational function of registered state only.
  - On src_valid[g] && src_ready[g]: hold_vld<=1, capture data and last. If last, set pkt_done.
  - tx_empty = !hold_vld, combinational from the register.
  - On tx_re && hold_vld: tx_din<=hold_data on the next edge (data valid the cycle after re, standard FIFO read latency) and hold_vld<=0.
  - If the consumed byte had last: next edge goes to IDLE, busy<=0, rr<=grant_id, pkt_done<=0. grant_id keeps its value.
  - tx_re while hold_vld=0: ignored; tx_din holds its value.
  - Requesting source drops valid mid-packet: grant is kept and the block waits.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter increments each LOCK cycle with hold_vld=0, pkt_done=0 and src_valid[g]=0.
  - It clears on any accepted byte and on entering LOCK.
  - When it reaches TIMEOUT_CYCLES-1: next edge returns to IDLE, busy<=0, rr<=grant_id, timeout_err pulses for 1 cycle, counter clears.
  - A byte still in hold (impossible by the counting condition) is never discarded.
- Simultaneous events:
  - Last-byte consumption and another source's valid in the same cycle: release first, arbitrate in the following IDLE cycle.
  - Every source valid continuously gives a strict rotation 0,1,2,3,0,…
- Throughput: at most one byte per 2 cycles (ample for UART).

Test Plan:
- Single source 1 sends packet "OK\n" (0x4F,0x4B,0x0A, last on 0x0A); bench transmitter pulls tx_re every 100 cycles -> tx_din sequence 4F,4B,0A each valid one cycle after tx_re; grant_id=1; busy drops the cycle after 0x0A is consumed.
- Sources 0 and 2 both hold 2-byte packets from reset -> source 0 packet completes fully, then source 2; no interleaving; then source 0 again only if re-requested.
- All 4 sources continuously valid with 1-byte packets -> grant order 0,1,2,3,0,1; each tx_din carries its source's byte.
- TIMEOUT_CYCLES=50: source 3 sends 1 byte without last, then drops valid -> after 50 idle cycles timeout_err pulses once, busy=0, and source 0's pending packet is granted next.
- tx_re pulsed while tx_empty=1 -> tx_din unchanged, no src_ready asserted outside LOCK.
- Assert rst_n low mid-packet (hold_vld=1) -> immediately tx_empty=1, busy=0, src_ready=0; after release, source 0 has first priority.
